// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Purpose : field-width derivation from the total float width, the
//           alignment FSM state type and the guard/round/sticky record.
// Ports   : none (package).
package fpu_pkg;

    // Exponent field width: 8 for binary32, 11 for binary64.
    function automatic int exp_width(input int size);
        return 5 + ($clog2(size) - 4) * 3;
    endfunction

    // Stored fraction width (sign and exponent removed).
    function automatic int frac_width(input int size);
        return size - exp_width(size) - 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } grs_t;

endpackage

// File: rtl/fp_align_grs_if.sv
// Request/result bundle of the right-alignment shifter.
// Purpose : carries the request handshake (i_valid/o_ready), the operand
//           (i_hidden, i_fraction, i_shift), the result handshake
//           (o_valid/i_ready) and the result (o_hidden, o_fraction, o_GRS).
// Modports: slave  - the shifter itself.
//           master - the block driving requests and taking results.
interface fp_align_grs_if #(
    parameter int SIZE = 64
);
    localparam int EXPONENT = fpu_pkg::exp_width(SIZE);
    localparam int FRACTION = fpu_pkg::frac_width(SIZE);

    logic                i_valid;
    logic                o_ready;
    logic                i_hidden;
    logic [FRACTION-1:0] i_fraction;
    logic [EXPONENT-1:0] i_shift;
    logic                o_valid;
    logic                i_ready;
    logic                o_hidden;
    logic [FRACTION-1:0] o_fraction;
    logic [2:0]          o_GRS;

    modport slave (
        input  i_valid, i_hidden, i_fraction, i_shift, i_ready,
        output o_ready, o_valid, o_hidden, o_fraction, o_GRS
    );

    modport master (
        output i_valid, i_hidden, i_fraction, i_shift, i_ready,
        input  o_ready, o_valid, o_hidden, o_fraction, o_GRS
    );

endinterface

// File: rtl/fp_grs_step.sv
// Single-bit right shift with guard/round/sticky tracking.
// Purpose : combinational next-state of {m, g, r, s} for one shift position;
//           shared with the normalizer.
// Ports   : m        - current mantissa (W bits)
//           grs      - current guard/round/sticky
//           m_next   - mantissa shifted right by one, zero filled
//           grs_next - guard takes the bit shifted out, round takes the old
//                      guard, sticky absorbs the old round
module fp_grs_step
    import fpu_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] m,
    input  grs_t         grs,
    output logic [W-1:0] m_next,
    output grs_t         grs_next
);

    assign m_next   = {1'b0, m[W-1:1]};
    assign grs_next = '{guard:  m[0],
                        round:  grs.guard,
                        sticky: grs.sticky | grs.round};

endmodule

// File: rtl/fp_align_grs.sv
// Iterative right-alignment shifter producing guard/round/sticky.
// Purpose : accepts {hidden, fraction} and an unsigned right-shift amount,
//           shifts one bit per clock, and presents the aligned mantissa with
//           its GRS triple to the rounder.  Zero shifts and shifts that push
//           every bit past the round position finish on the accept edge.
// Ports   : i_clk   - clock
//           i_rst_n - synchronous active-low reset
//           bus     - fp_align_grs_if.slave (request, result, handshakes)
module fp_align_grs
    import fpu_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fp_align_grs_if.slave bus
);

    localparam int EXPONENT = exp_width(SIZE);
    localparam int FRACTION = frac_width(SIZE);
    // At this distance even the hidden bit lands below the round position.
    localparam int SAT      = FRACTION + 3;

    localparam logic [EXPONENT-1:0] SAT_V = EXPONENT'(SAT);
    localparam logic [EXPONENT-1:0] ONE_V = EXPONENT'(1);

    state_t              state, state_next;
    logic [EXPONENT-1:0] count, count_next;
    logic [FRACTION:0]   m, m_next, m_step;
    grs_t                grs, grs_next, grs_step;

    fp_grs_step #(
        .W(FRACTION + 1)
    ) u_step (
        .m       (m),
        .grs     (grs),
        .m_next  (m_step),
        .grs_next(grs_step)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            count <= '0;
            m     <= '0;
            grs   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            m     <= m_next;
            grs   <= grs_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        m_next     = m;
        grs_next   = grs;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    m_next   = {bus.i_hidden, bus.i_fraction};
                    grs_next = '0;
                    if (bus.i_shift == '0) begin
                        state_next = DONE;
                    end else if (bus.i_shift >= SAT_V) begin
                        // Whole mantissa folds into sticky in one step.
                        m_next          = '0;
                        grs_next.sticky = bus.i_hidden | (|bus.i_fraction);
                        state_next      = DONE;
                    end else begin
                        count_next = bus.i_shift;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                m_next     = m_step;
                grs_next   = grs_step;
                // count is at least 1 here, so this cannot wrap.
                count_next = count - ONE_V;
                if (count == ONE_V) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_ready    = (state == IDLE);
    assign bus.o_valid    = (state == DONE);
    assign bus.o_hidden   = m[FRACTION];
    assign bus.o_fraction = m[FRACTION-1:0];
    assign bus.o_GRS      = grs;

endmodule

// File: tb/tb_fp_align_grs.sv
// Bench for fp_align_grs at SIZE=32 (FRACTION=23, SAT=26).
// Directed vectors with hand-computed results are queued when issued; an
// independent monitor checks every cycle the result is presented.
module tb_fp_align_grs;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_align_grs_if #(.SIZE(32)) bus ();

    fp_align_grs #(
        .SIZE(32)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        h;
        logic [22:0] f;
        logic [2:0]  grs;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        h;
        logic [22:0] f;
        logic [7:0]  sh;
        logic        eh;
        logic [22:0] ef;
        logic [2:0]  eg;
        int          lat;
    } vec_t;

    exp_t q[$];
    vec_t vq[$];
    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares presented result against the queue head every cycle
    // o_valid is high, checks arrival cycle on the rising edge of o_valid,
    // and retires the entry on the handshake.
    initial begin : monitor
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_v = 1'b0;
            end else if (bus.o_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'(bus.o_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!prev_v) check("latency", 32'(cyc), 32'(e.cyc));
                    check("o_hidden", 32'(bus.o_hidden), 32'(e.h));
                    check("o_fraction", 32'(bus.o_fraction), 32'(e.f));
                    check("o_GRS", 32'(bus.o_GRS), 32'(e.grs));
                    if (bus.i_ready) void'(q.pop_front());
                end
                prev_v = !bus.i_ready;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    task automatic issue(input logic h, input logic [22:0] f, input logic [7:0] sh,
                         input logic eh, input logic [22:0] ef, input logic [2:0] eg,
                         input int lat, input bit want);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.i_valid    = 1'b1;
        bus.i_hidden   = h;
        bus.i_fraction = f;
        bus.i_shift    = sh;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            check("accept_timeout", 32'(bus.o_ready), 32'd1);
            bus.i_valid = 1'b0;
            return;
        end
        if (want) begin
            e.h   = eh;
            e.f   = ef;
            e.grs = eg;
            e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs: the operation in flight must not see them.
        bus.i_valid    = 1'b0;
        bus.i_hidden   = ~h;
        bus.i_fraction = ~f;
        bus.i_shift    = sh + 8'd1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.o_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_o_ready"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_o_hidden"}, 32'(bus.o_hidden), 32'd0);
        check({tag, "_o_fraction"}, 32'(bus.o_fraction), 32'd0);
        check({tag, "_o_GRS"}, 32'(bus.o_GRS), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        bus.i_valid    = 1'b0;
        bus.i_hidden   = 1'b0;
        bus.i_fraction = '0;
        bus.i_shift    = '0;
        bus.i_ready    = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        //             h     f            sh      eh    ef           grs     lat
        vq.push_back('{1'b1, 23'h000001, 8'd0,   1'b1, 23'h000001, 3'b000, 0});
        vq.push_back('{1'b1, 23'h000007, 8'd3,   1'b0, 23'h100000, 3'b111, 3});
        vq.push_back('{1'b1, 23'h000002, 8'd2,   1'b0, 23'h200000, 3'b100, 2});
        vq.push_back('{1'b1, 23'h000000, 8'd30,  1'b0, 23'h000000, 3'b001, 0});
        vq.push_back('{1'b0, 23'h000000, 8'd30,  1'b0, 23'h000000, 3'b000, 0});
        vq.push_back('{1'b1, 23'h000001, 8'd1,   1'b0, 23'h400000, 3'b100, 1});
        vq.push_back('{1'b1, 23'h000003, 8'd2,   1'b0, 23'h200000, 3'b110, 2});
        vq.push_back('{1'b0, 23'h7FFFFF, 8'd4,   1'b0, 23'h07FFFF, 3'b111, 4});
        vq.push_back('{1'b1, 23'h400000, 8'd23,  1'b0, 23'h000001, 3'b100, 23});
        vq.push_back('{1'b1, 23'h000000, 8'd24,  1'b0, 23'h000000, 3'b100, 24});
        vq.push_back('{1'b1, 23'h000001, 8'd25,  1'b0, 23'h000000, 3'b011, 25});
        vq.push_back('{1'b0, 23'h000010, 8'd26,  1'b0, 23'h000000, 3'b001, 0});
        vq.push_back('{1'b1, 23'h7FFFFF, 8'd255, 1'b0, 23'h000000, 3'b001, 0});

        foreach (vq[i]) begin
            issue(vq[i].h, vq[i].f, vq[i].sh, vq[i].eh, vq[i].ef, vq[i].eg, vq[i].lat, 1'b1);
        end
        drain();

        // Backpressure: result held, new requests ignored.
        bus.i_ready = 1'b0;
        issue(1'b1, 23'h000007, 8'd3, 1'b0, 23'h100000, 3'b111, 3, 1'b1);
        n = 0;
        while (!bus.o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 32'(bus.o_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            bus.i_valid    = 1'b1;
            bus.i_hidden   = 1'b1;
            bus.i_fraction = 23'h000123;
            bus.i_shift    = 8'd0;
            check("bp_o_ready", 32'(bus.o_ready), 32'd0);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_o_valid", 32'(bus.o_valid), 32'd0);
        check("bp_release_o_ready", 32'(bus.o_ready), 32'd1);
        drain();

        // Reset in the middle of a 20-position shift.
        issue(1'b1, 23'h000000, 8'd20, 1'b0, 23'h000000, 3'b000, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        issue(1'b1, 23'h000007, 8'd3, 1'b0, 23'h100000, 3'b111, 3, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/fp_align_grs.md
Name: fp_align_grs

Overview:
- Iterative right-alignment shifter for the parametrizable FPU.
- Takes a fraction with explicit hidden bit and a right-shift amount. Examples: the exponent difference in add/sub, or the denormalizing shift.
- Shifts one bit per cycle and generates the guard/round/sticky triple consumed by the rounding stage.
- Sits between exponent compare and the adder/rounder; it is the producer of the GRS bits and the fraction the rounder consumes.

Parameters:
- SIZE, 64, total float width.
- EXPONENT, 5 + (clog2(SIZE)-4)*3, exponent field width (11 for 64, 8 for 32).
- FRACTION, SIZE-EXPONENT-1, stored fraction width.
- SAT, FRACTION+3, shift count at or above which all mantissa bits fold into sticky.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  input request.
- o_ready  out  1  block idle, can accept.
- i_hidden  in  1  hidden bit (1 normal, 0 denormal/zero).
- i_fraction  in  FRACTION  stored fraction.
- i_shift  in  EXPONENT  right-shift amount, unsigned.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts result.
- o_hidden  out  1  bit FRACTION of shifted mantissa.
- o_fraction  out  FRACTION  shifted mantissa low bits.
- o_GRS  out  3  {guard, round, sticky}.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset has priority over all other activity, including mid-operation:
  - state := IDLE, count := 0, mantissa := 0, GRS := 000.
  - o_valid=0, o_ready=1 (after the reset edge), o_hidden=0, o_fraction=0, o_GRS=000.
- Internal registers:
  - m[FRACTION:0] (mantissa incl. hidden bit).
  - g, r, s.
  - count of width EXPONENT.
- States: IDLE, SHIFT, DONE. o_ready = (state==IDLE); o_valid = (state==DONE).
- Outputs are driven directly from m, g, r, s. Values are only meaningful when o_valid=1, but still deterministic otherwise.
- IDLE, on i_valid (accept edge):
  - m := {i_hidden, i_fraction}; g,r,s := 0.
  - If i_shift==0: -> DONE with mantissa unchanged, GRS=000.
  - Else if i_shift >= SAT: m := 0, g := 0, r := 0, s := OR of {i_hidden, i_fraction}; -> DONE.
  - Else count := i_shift; -> SHIFT.
- SHIFT, each edge:
  - m := m >> 1 (zero fill); g := m[0]; r := g; s := s | r (all using old values); count := count-1.
  - When old count==1, -> DONE.
- Latency: o_valid rises after accept edge + N edges for 1 <= N < SAT. It rises after the accept edge itself for N==0 or N >= SAT.
- DONE:
  - Hold all outputs stable until i_ready=1.
  - On o_valid & i_ready -> IDLE. o_ready returns high the next cycle; there is no same-cycle re-accept.
- i_valid while not IDLE: ignored, no state change. The upstream must hold the request until o_ready.
- Inputs are sampled only on the accept edge. Later input changes do not affect the operation in flight.
- Sticky is sticky: once set, it stays set for that operation.
- Width rule: count never underflows. i_shift values up to 2^EXPONENT-1 are legal and take the saturation path.

Decomposition:
- Shared package fpu_pkg:
  - Function for the EXPONENT/FRACTION derivation from SIZE.
  - Typedef state enum {IDLE, SHIFT, DONE}.
  - Typedef for the 3-bit GRS struct {guard, round, sticky}.
- One natural sub-module: fp_grs_step, a combinational single-bit shift that produces the next {m, g, r, s} from the current values. It is reusable by a future normalizer.

Test Plan:
All scenarios use SIZE=32 (FRACTION=23, SAT=26).
1. i_hidden=1, i_fraction=0x000001, i_shift=0 -> o_valid one edge after accept; o_hidden=1, o_fraction=0x000001, o_GRS=000.
2. i_hidden=1, i_fraction=0x000007, i_shift=3 -> o_valid 3 edges after accept; o_hidden=0, o_fraction=0x100000, o_GRS=111.
3. i_hidden=1, i_fraction=0x000002, i_shift=2 -> o_fraction=0x200000, o_hidden=0, o_GRS=100 (tie case for rounder).
4. i_hidden=1, i_fraction=0, i_shift=30 -> o_valid after 1 edge; o_hidden=0, o_fraction=0, o_GRS=001. Repeat with i_hidden=0, i_fraction=0 -> o_GRS=000.
5. Backpressure: shift=3 result held with i_ready=0 for 5 cycles -> outputs constant, o_ready=0, and a new i_valid during this time is ignored. Then i_ready=1 -> o_valid drops next cycle, o_ready=1.
6. Reset mid-operation: shift=20 accepted, i_rst_n=0 on the 5th cycle -> all outputs 0 and o_ready=1 after the reset edge. A subsequent scenario-2 request completes correctly.
